// File: rtl/crc_pkg.sv
// Shared CRC-16 (x^16+x^12+x^5+1) constants and FSM state type, common to
// the PUSCH CRC16 generator and the receive-side checker.
package crc_pkg;

   localparam int CRC_W = 16;

   // Feedback taps land on bits 0, 5 and 12 of the LFSR.
   localparam logic [CRC_W-1:0] CRC16_POLY_TAPS = 16'h1021;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PAYLOAD = 2'd1,
      PARITY  = 2'd2,
      REPORT  = 2'd3
   } crc_state_t;

endpackage

// File: rtl/crc16_lfsr_step.sv
// Single-bit CRC-16 LFSR update, shared with the transmitter so both ends
// use an identical bit mapping. Holds the register when en is low.
module crc16_lfsr_step
   import crc_pkg::*;
(
   input  logic [CRC_W-1:0] lfsr,
   input  logic             data,
   input  logic             en,
   output logic [CRC_W-1:0] next
);

   logic fb;

   assign fb = data ^ lfsr[0];

   // Shift toward the MSB; tap bit 0 of the mask also injects fb into bit 0.
   always_comb begin
      next = lfsr;
      if (en) begin
         next = {lfsr[CRC_W-2:0], 1'b0} ^ ({CRC_W{fb}} & CRC16_POLY_TAPS);
      end
   end

endmodule

// File: rtl/crc16_checker.sv
// Receive-side CRC-16 checker: recomputes the CRC over LEN payload bits and
// compares it with the 16 received parity bits. Define CRC16_ERR_CNT_EN to add ERR_CNT.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   IDLE    | waiting for START
//   PAYLOAD | shifting payload bits through the LFSR
//   PARITY  | collecting 16 received parity bits, LFSR frozen
//   REPORT  | one cycle; next edge raises DONE with the compare result
module crc16_checker
   import crc_pkg::*;
#(
   parameter logic [CRC_W-1:0] SEED  = 16'h0000,
   parameter int               LEN_W = 16
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             START,
   input  logic [LEN_W-1:0] LEN,
   input  logic             DATA,
   input  logic             DATA_VALID,
   output logic             BUSY,
   output logic             DONE,
   output logic             CRC_OK
`ifdef CRC16_ERR_CNT_EN
   ,
   output logic [15:0]      ERR_CNT
`endif
);

   localparam logic [LEN_W-1:0] CNT_ONE = LEN_W'(1);
   localparam logic [LEN_W-1:0] PAR_CNT = LEN_W'(CRC_W);

   crc_state_t       state;
   logic [LEN_W-1:0] cnt;
   logic [CRC_W-1:0] lfsr;
   logic [CRC_W-1:0] lfsr_next;
   logic [CRC_W-1:0] rx_par;
   logic             step_en;

   assign step_en = (state == PAYLOAD) && DATA_VALID;

   crc16_lfsr_step u_lfsr_step (
      .lfsr (lfsr),
      .data (DATA),
      .en   (step_en),
      .next (lfsr_next)
   );

   always_ff @(posedge CLK) begin
      if (RST) begin
         state  <= IDLE;
         cnt    <= '0;
         lfsr   <= SEED;
         rx_par <= '0;
         BUSY   <= 1'b0;
         DONE   <= 1'b0;
         CRC_OK <= 1'b0;
      end else begin
         DONE <= 1'b0;
         // START in any state begins a fresh frame, dropping any frame in flight.
         if (START) begin
            lfsr   <= SEED;
            rx_par <= '0;
            CRC_OK <= 1'b0;
            BUSY   <= 1'b1;
            if (LEN == '0) begin
               cnt   <= PAR_CNT;
               state <= PARITY;
            end else begin
               cnt   <= LEN;
               state <= PAYLOAD;
            end
         end else begin
            case (state)
               IDLE: begin
                  state <= IDLE;
               end
               PAYLOAD: begin
                  if (DATA_VALID) begin
                     lfsr <= lfsr_next;
                     if (cnt == CNT_ONE) begin
                        cnt   <= PAR_CNT;
                        state <= PARITY;
                     end else begin
                        cnt <= cnt - CNT_ONE;
                     end
                  end
               end
               PARITY: begin
                  if (DATA_VALID) begin
                     rx_par <= {rx_par[CRC_W-2:0], DATA};
                     cnt    <= cnt - CNT_ONE;
                     if (cnt == CNT_ONE) begin
                        state <= REPORT;
                     end
                  end
               end
               REPORT: begin
                  DONE   <= 1'b1;
                  BUSY   <= 1'b0;
                  CRC_OK <= (rx_par == lfsr);
                  state  <= IDLE;
               end
               default: begin
                  state <= IDLE;
               end
            endcase
         end
      end
   end

`ifdef CRC16_ERR_CNT_EN
   // Counts reported failures only; a START landing on REPORT suppresses the report.
   always_ff @(posedge CLK) begin
      if (RST) begin
         ERR_CNT <= '0;
      end else if ((state == REPORT) && !START && (rx_par != lfsr) &&
                   (ERR_CNT != 16'hFFFF)) begin
         ERR_CNT <= ERR_CNT + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_crc16_checker.sv
// Self-checking bench for crc16_checker: frame-level reference model plus
// directed frames with hand-computed parity.
module tb_crc16_checker;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [15:0] len = '0;
   logic        data = 1'b0;
   logic        dv = 1'b0;
   logic        busy, done, crc_ok;
`ifdef CRC16_ERR_CNT_EN
   logic [15:0] err_cnt;
`endif

   always #5 clk = ~clk;

   crc16_checker #(.SEED(16'h0000), .LEN_W(16)) dut (
      .CLK        (clk),
      .RST        (rst),
      .START      (start),
      .LEN        (len),
      .DATA       (data),
      .DATA_VALID (dv),
`ifdef CRC16_ERR_CNT_EN
      .ERR_CNT    (err_cnt),
`endif
      .BUSY       (busy),
      .DONE       (done),
      .CRC_OK     (crc_ok)
   );

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int done_cnt = 0;
   int done_cyc = 0;
   int start_cyc = 0;
   logic last_ok = 1'b0;
   bit chk_en = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic void chk(string nm, int act, int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endfunction

   // Reference CRC: bit-indexed polynomial division as the frame rules describe it.
   function automatic logic [15:0] model_crc(logic bits[$], int n);
      logic [15:0] r;
      logic [15:0] nx;
      logic        fb;
      r = 16'h0000;
      for (int k = 0; k < n; k++) begin
         fb = bits[k] ^ r[0];
         nx[0] = fb;
         for (int i = 1; i < 16; i++)
            nx[i] = r[i-1] ^ (((i == 5) || (i == 12)) ? fb : 1'b0);
         r = nx;
      end
      return r;
   endfunction

   function automatic logic frame_ok(logic bits[$], int n);
      logic [15:0] p;
      p = 16'h0000;
      for (int k = 0; k < 16; k++) p = {p[14:0], bits[n+k]};
      return p == model_crc(bits, n);
   endfunction

   // Frame-level model: collect LEN+16 accepted bits, report one cycle later.
   logic        m_busy = 1'b0, m_done = 1'b0, m_ok = 1'b0;
   logic        m_active = 1'b0, m_report = 1'b0;
   int          m_need = 0, m_len = 0;
   logic        m_bits[$];
   logic [15:0] m_err = '0;

   always @(posedge clk) begin
      m_done = 1'b0;
      if (rst) begin
         m_busy = 0; m_ok = 0; m_active = 0; m_report = 0; m_err = '0;
         m_bits.delete();
      end else if (start) begin
         m_len = int'(len); m_need = int'(len) + 16;
         m_bits.delete();
         m_active = 1; m_report = 0; m_busy = 1; m_ok = 0;
      end else if (m_report) begin
         m_report = 0; m_done = 1; m_busy = 0;
         m_ok = frame_ok(m_bits, m_len);
         if (!m_ok && m_err != 16'hFFFF) m_err = m_err + 16'd1;
      end else if (m_active && dv) begin
         m_bits.push_back(data);
         if (m_bits.size() == m_need) begin
            m_active = 0; m_report = 1;
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("busy", int'(busy), int'(m_busy));
         chk("done", int'(done), int'(m_done));
         chk("crc_ok", int'(crc_ok), int'(m_ok));
`ifdef CRC16_ERR_CNT_EN
         chk("err_cnt", int'(err_cnt), int'(m_err));
`endif
         if (done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
            last_ok  = crc_ok;
         end
      end
   end

   logic q[$];

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic add(logic [15:0] val, int n);
      for (int i = n - 1; i >= 0; i--) q.push_back(val[i]);
   endtask

   task automatic send_start(int l);
      start = 1'b1; len = l[15:0]; dv = 1'b0;
      tick();
      start = 1'b0;
      start_cyc = cyc;
   endtask

   task automatic send_bits(bit toggle);
      for (int i = 0; i < q.size(); i++) begin
         data = q[i]; dv = 1'b1;
         tick();
         if (toggle) begin
            data = ~q[i]; dv = 1'b0;
            tick();
         end
      end
      dv = 1'b0; data = 1'b0;
   endtask

   task automatic run_frame(int l, bit toggle);
      send_start(l);
      send_bits(toggle);
   endtask

   int d0;
   int rl;
   logic [15:0] par;

   initial begin
      repeat (3) tick();
      rst = 1'b0;
      chk_en = 1'b1;
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_crc_ok", int'(crc_ok), 0);
      q.delete(); q.push_back(1'b1);
      chk("model_pin_1021", int'(model_crc(q, 1)), 16'h1021);
      tick();

      // LEN=8, all zeros
      q.delete(); add(16'h0000, 8); add(16'h0000, 16);
      d0 = done_cnt;
      run_frame(8, 0);
      repeat (3) tick();
      chk("len8_latency", done_cyc - start_cyc, 25);
      chk("len8_ok", int'(last_ok), 1);
      chk("len8_ndone", done_cnt - d0, 1);

      // LEN=1, payload 1, parity 0x1021
      q.delete(); add(16'h0001, 1); add(16'h1021, 16);
      run_frame(1, 0);
      repeat (3) tick();
      chk("len1_latency", done_cyc - start_cyc, 18);
      chk("len1_ok", int'(last_ok), 1);

      q.delete(); add(16'h0001, 1); add(16'h1020, 16);
      run_frame(1, 0);
      repeat (3) tick();
      chk("len1_flip_ok", int'(last_ok), 0);
`ifdef CRC16_ERR_CNT_EN
      chk("len1_flip_errcnt", int'(err_cnt), 1);
`endif

      // Same good frame with DATA_VALID toggling
      q.delete(); add(16'h0001, 1); add(16'h1021, 16);
      run_frame(1, 1);
      repeat (3) tick();
      chk("toggle_latency", done_cyc - start_cyc, 34);
      chk("toggle_ok", int'(last_ok), 1);

      // LEN=0
      q.delete(); add(16'h0000, 16);
      run_frame(0, 0);
      repeat (3) tick();
      chk("len0_ok", int'(last_ok), 1);
      chk("len0_latency", done_cyc - start_cyc, 17);
      q.delete(); add(16'h0001, 16);
      run_frame(0, 0);
      repeat (3) tick();
      chk("len0_bad_ok", int'(last_ok), 0);

      // Abort mid-payload, restart with good LEN=1 frame
      d0 = done_cnt;
      q.delete(); add(16'h000A, 4);
      run_frame(8, 0);
      q.delete(); add(16'h0001, 1); add(16'h1021, 16);
      run_frame(1, 0);
      repeat (3) tick();
      chk("abort_ndone", done_cnt - d0, 1);
      chk("abort_ok", int'(last_ok), 1);

      // START lands on REPORT of a bad frame: that report is dropped
      d0 = done_cnt;
      q.delete(); add(16'h0001, 1); add(16'h1020, 16);
      run_frame(1, 0);
      q.delete(); add(16'h0001, 1); add(16'h1021, 16);
      run_frame(1, 0);
      repeat (3) tick();
      chk("report_abort_ndone", done_cnt - d0, 1);
      chk("report_abort_ok", int'(last_ok), 1);

      // Random payloads with correct and corrupted parity
      for (int f = 0; f < 4; f++) begin
         rl = $urandom_range(2, 40);
         q.delete();
         for (int i = 0; i < rl; i++) q.push_back(1'($urandom_range(0, 1)));
         par = model_crc(q, rl);
         add(par, 16);
         if (f[0]) q[rl/2] = ~q[rl/2];
         run_frame(rl, f[1]);
         repeat (3) tick();
         chk("rand_ok", int'(last_ok), f[0] ? 0 : 1);
      end

      // Reset mid-parity
      q.delete(); add(16'h0003, 2); add(16'h0015, 5);
      send_start(2);
      send_bits(0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("midrst_busy", int'(busy), 0);
      chk("midrst_done", int'(done), 0);
      d0 = done_cnt;
      for (int i = 0; i < 24; i++) begin
         data = 1'($urandom_range(0, 1)); dv = 1'b1;
         tick();
      end
      dv = 1'b0;
      repeat (3) tick();
      chk("midrst_no_done", done_cnt - d0, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/crc16_checker.md
Name: crc16_checker

Overview:
- Receive-side counterpart of the PUSCH CRC16 generator. Consumes a serial frame of LEN payload bits followed by 16 parity bits.
- Recomputes CRC-16 (x^16+x^12+x^5+1) over the payload using the generator's exact LFSR mapping, then compares the result with the received parity.
- Reports pass/fail with a one-cycle DONE pulse. Sits after the descrambler/decoder in the receive chain.

Parameters:
SEED, 16'h0000, initial LFSR value; must equal the transmitter's SEED
LEN_W, 16, width of the payload length input and internal bit counter

Ports:
CLK  input  1  clock, all logic on rising edge
RST  input  1  synchronous reset, active-high
START  input  1  one-cycle pulse; latches LEN and begins a new frame
LEN  input  LEN_W  payload length in bits, excluding the 16 parity bits; sampled when START=1
DATA  input  1  serial frame bit
DATA_VALID  input  1  DATA is consumed on cycles where this is 1
BUSY  output  1  high from the cycle after START until the cycle DONE is asserted
DONE  output  1  one-cycle pulse when the check completes
CRC_OK  output  1  result; valid while DONE=1 and held until the next START

Behaviour:
- Clock and reset: one clock, CLK. RST is synchronous and active-high.
- Reset values: BUSY=0, DONE=0, CRC_OK=0. Internally LFSR=SEED, rx_par=0, cnt=0, state=IDLE.
- FSM states are IDLE, PAYLOAD, PARITY and REPORT.
- IDLE: on START, latch LEN into cnt and load LFSR=SEED, rx_par=0, CRC_OK=0.
  - If LEN=0, go to PARITY with cnt=16.
  - Otherwise go to PAYLOAD.
- PAYLOAD: on each DATA_VALID cycle:
  - fb = DATA ^ LFSR[0].
  - LFSR shifts toward the MSB: LFSR[0]<=fb, LFSR[5]<=LFSR[4]^fb, LFSR[12]<=LFSR[11]^fb, and every other bit i<=LFSR[i-1].
  - cnt decrements. When cnt reaches 1 and a bit is consumed, go to PARITY with cnt=16.
- PARITY: on each DATA_VALID cycle, rx_par <= {rx_par[14:0], DATA} and the LFSR holds.
  - Transmit order is LFSR[15] first, so after 16 bits rx_par[15] holds the first parity bit.
  - After the 16th bit go to REPORT.
- REPORT: lasts one cycle.
  - DONE=1 and CRC_OK=(rx_par==LFSR).
  - BUSY=0 in the same cycle, then return to IDLE.
- Latency: DONE occurs 1 cycle after the last parity bit is consumed.
- DATA_VALID=0 in PAYLOAD or PARITY stalls all state; there is no timeout.
- START while in PAYLOAD, PARITY or REPORT aborts the current frame and restarts with the new LEN.
  - No DONE is produced for the aborted frame.
  - If START coincides with REPORT, the new frame wins and DONE is suppressed.
- DATA_VALID in IDLE is ignored.
- RST mid-frame returns to IDLE with the reset values above; the partial frame is discarded.
- cnt is LEN_W bits and only decrements, so there is no wrap. The maximum frame length is 2^LEN_W-1 payload bits.

Optional Feature:
- CRC16_ERR_CNT_EN defined:
  - Adds output ERR_CNT [15:0], reset to 0.
  - Increments by 1 on each DONE with CRC_OK=0 and saturates at 16'hFFFF.
  - Cleared only by RST.
- Not defined: no port and no counter logic.

Decomposition:
- Shared package crc_pkg holds:
  - CRC16_POLY_TAPS (bits 0, 5, 12),
  - CRC_W=16,
  - the FSM state enum (IDLE, PAYLOAD, PARITY, REPORT).
- The generator should reuse the same constants.
- One natural sub-module, crc16_lfsr_step: a single-bit LFSR update (inputs lfsr, data, en; output next). It is shared with the transmitter so both sides use an identical bit mapping.

Test Plan:
- START with LEN=8, then 8 zero bits followed by 16 zero bits, DATA_VALID always 1 -> DONE at cycle 25 after START, CRC_OK=1, BUSY low from that cycle.
- START with LEN=1, payload bit 1, then parity 0,0,0,1,0,0,0,0,0,0,1,0,0,0,0,1 (LFSR=16'h1021) -> CRC_OK=1. Repeat with the last parity bit flipped -> CRC_OK=0, and ERR_CNT=1 when CRC16_ERR_CNT_EN is defined.
- Same frame as the LEN=1 case, with DATA_VALID toggled 1/0 every cycle -> identical result, DONE delayed to about 2x the cycles.
- LEN=0 with 16 zero parity bits -> CRC_OK=1. LEN=0 with parity 16'h0001 -> CRC_OK=0.
- Abort and reset:
  - START LEN=8, send 4 bits, then START again with LEN=1 and send the valid 16'h1021 frame -> exactly one DONE, with CRC_OK=1.
  - RST asserted mid-PARITY -> BUSY=0, DONE=0, no DONE until the next START.
